// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants and receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_data_bits_default    = 8;
    localparam int c_clks_per_bit_default = 434;   // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Two-flop synchronizer for the serial line, resets to idle-high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : UART receiver, LSB-first, mid-bit sampling; optional even parity
//            when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_clks_per_bit_default,
    parameter int DATA_BITS    = c_data_bits_default
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_waveform,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int                c_tw       = $clog2(CLKS_PER_BIT);
    localparam int                c_iw       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_tw-1:0]   c_half_m1  = c_tw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_tw-1:0]   c_full_m1  = c_tw'(CLKS_PER_BIT - 1);
    localparam logic [c_iw-1:0]   c_last_idx = c_iw'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [c_tw-1:0]      r_timer;
    logic [c_iw-1:0]      r_idx;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
`endif

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_waveform),
        .q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            data_received <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
            r_par_bad     <= 1'b0;
`endif
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_timer <= '0;
                    end
                end
                // Re-check the start bit at its midpoint to reject glitches.
                START: begin
                    if (r_timer == c_half_m1) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                            r_timer <= '0;
                            r_idx   <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DATA: begin
                    if (r_timer == c_full_m1) begin
                        r_timer <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_timer == c_full_m1) begin
                        r_timer   <= '0;
                        r_par_bad <= w_rx_s ^ (^r_shift);
                        r_state   <= STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_timer == c_full_m1) begin
                        r_timer <= '0;
                        if (!w_rx_s) begin
                            framing_error <= 1'b1;
                            r_state       <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            parity_error <= 1'b1;
                            r_state      <= IDLE;
`endif
                        end else begin
                            data_received <= r_shift;
                            data_valid    <= 1'b1;
                            r_state       <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                // Hold off through a break so it reports only one error.
                WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_error = 1'b0;
`endif

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Directed self-checking bench for uart_receiver (CLKS_PER_BIT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int c_lat = 171;   // start edge to data_valid, 11-bit frame
`else
    localparam int c_lat = 155;   // 9 bits + half stop bit + 3 cycles
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_received;
    logic       data_valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         overlap_cnt = 0;
    int         t_start = 0;
    int         t_valid = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] rx_log[$];

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_waveform   (rx),
        .data_received (data_received),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            rx_log.push_back(data_received);
            t_valid = cyc;
        end
        if (framing_error) fe_cnt++;
        if (parity_error)  pe_cnt++;
        if (busy)          busy_seen = 1'b1;
        if (int'(data_valid) + int'(framing_error) + int'(parity_error) > 1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ ~par_ok);
`else
        if (!par_ok) $display("note: parity not compiled in");
`endif
        send_bit(stop_b);
    endtask

    initial begin
        wait_cycles(5);
        check("rst_data",  32'(data_received), 32'h00);
        check("rst_dv",    32'(data_valid),    32'h0);
        check("rst_fe",    32'(framing_error), 32'h0);
        check("rst_pe",    32'(parity_error),  32'h0);
        check("rst_busy",  32'(busy),          32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // Basic frame
        send_frame(8'hAA, 1'b1, 1'b1);
        wait_cycles(20);
        check("aa_count",   32'(dv_cnt),           32'd1);
        check("aa_data",    32'(data_received),    32'hAA);
        check("aa_latency", 32'(t_valid - t_start), 32'(c_lat));
        check("aa_errs",    32'(fe_cnt + pe_cnt),  32'd0);
        check("aa_busy",    32'(busy),             32'h0);

        // Short low glitch on an idle line
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_busy_seen", 32'(busy_seen),       32'h1);
        check("glitch_busy_end",  32'(busy),            32'h0);
        check("glitch_pulses",    32'(dv_cnt + fe_cnt + pe_cnt), 32'd1);

        // Bad stop bit followed by a held-low break
        send_frame(8'h55, 1'b0, 1'b1);
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(20);
        check("fe_count", 32'(fe_cnt),        32'd1);
        check("fe_dv",    32'(dv_cnt),        32'd1);
        check("fe_data",  32'(data_received), 32'hAA);
        check("fe_busy",  32'(busy),          32'h0);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_cycles(20);
        check("post_fe_count", 32'(dv_cnt),        32'd2);
        check("post_fe_data",  32'(data_received), 32'h3C);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_cycles(20);
        check("b2b_count",  32'(dv_cnt),    32'd4);
        check("b2b_first",  32'(rx_log[2]), 32'h00);
        check("b2b_second", 32'(rx_log[3]), 32'hFF);

        // Reset during data bit 3 of 8'hC3
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        wait_cycles(8);
        rst = 1'b1;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(3);
        check("midrst_data", 32'(data_received), 32'h00);
        check("midrst_busy", 32'(busy),          32'h0);
        check("midrst_dv",   32'(data_valid),    32'h0);
        rst = 1'b0;
        wait_cycles(40);
        check("postrst_dv",   32'(dv_cnt),        32'd4);
        check("postrst_fe",   32'(fe_cnt),        32'd1);
        check("postrst_data", 32'(data_received), 32'h00);
        check("postrst_busy", 32'(busy),          32'h0);
        send_frame(8'h81, 1'b1, 1'b1);
        wait_cycles(20);
        check("r81_count", 32'(dv_cnt),        32'd5);
        check("r81_data",  32'(data_received), 32'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(20);
        check("par_bad_pe",   32'(pe_cnt),        32'd1);
        check("par_bad_dv",   32'(dv_cnt),        32'd5);
        check("par_bad_data", 32'(data_received), 32'h81);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(20);
        check("par_ok_dv",   32'(dv_cnt),        32'd6);
        check("par_ok_data", 32'(data_received), 32'h07);
`else
        check("pe_tied", 32'(pe_cnt), 32'd0);
`endif

        check("exclusive", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame.
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 rx_waveform  input  1  SHALL be the asynchronous serial line (idle high), driven by uart_transmitter tx_waveform.
REQ-006 data_received  output  8  SHALL hold the last correctly framed byte.
REQ-007 data_valid  output  1  SHALL be a one-cycle pulse when data_received updates.
REQ-008 framing_error  output  1  SHALL be a one-cycle pulse on a bad stop bit.
REQ-009 parity_error  output  1  SHALL be a one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 rx_waveform SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal rx_s.
REQ-012 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, and WAIT_HIGH.
REQ-013 IDLE: rx_s low SHALL enter START and clear the bit-timer.
REQ-014 START: at timer = CLKS_PER_BIT/2-1 (integer division), rx_s high SHALL return to IDLE with no output pulse (glitch rejection); rx_s low SHALL enter DATA and clear the timer and bit index.
REQ-015 DATA: every CLKS_PER_BIT cycles, rx_s SHALL be sampled into a shift register LSB-first; after DATA_BITS samples, the FSM SHALL enter PARITY if compiled in, else STOP.
REQ-016 STOP: one CLKS_PER_BIT after the last data/parity sample, rx_s high with no parity error SHALL load data_received and pulse data_valid on the next cycle, then enter IDLE.
REQ-017 STOP sample low SHALL pulse framing_error, leave data_received unchanged, and enter WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL stay until rx_s is high, then enter IDLE, so a break condition produces exactly one framing_error.
REQ-019 Latency SHALL be rx_waveform stop-bit midpoint + 3 cycles (2 sync + 1 register) to the data_valid pulse.
REQ-020 data_valid, framing_error and parity_error SHALL be mutually exclusive in any cycle.
REQ-021 A new start edge SHALL be accepted in the cycle after returning to IDLE (back-to-back frames with no idle gap).
REQ-022 The timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap only by explicit clear, never by overflow.

Reset
REQ-023 rst SHALL force state IDLE, timer 0, bit index 0, shift register 0, sync flops 1, data_received 8'h00, and data_valid/framing_error/parity_error/busy 0.
REQ-024 rst asserted mid-frame SHALL abandon the frame with no pulse; after release the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined SHALL enable the PARITY state, which samples one even-parity bit after the data bits; a mismatch SHALL pulse parity_error at the STOP decision instead of data_valid, and data_received SHALL not update.
REQ-026 Macro UART_RX_PARITY_EN undefined SHALL remove the PARITY state and logic; frame = start + DATA_BITS + stop; parity_error tied 0.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS default, and the default CLKS_PER_BIT constant, shared with uart_transmitter.
REQ-028 Sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated once; the FSM, timer and shift register stay in uart_receiver.

Verification (bench uses CLKS_PER_BIT=16)
REQ-029 Frame 8'b10101010 driven by uart_transmitter -> exactly one data_valid, data_received=8'hAA, no error pulses.
REQ-030 Low glitch of 4 cycles on an idle line -> busy pulses briefly, no data_valid or error pulses, FSM back in IDLE.
REQ-031 Frame 8'h55 with the stop bit forced low, then the line held low 40 cycles -> one framing_error, data_received keeps its prior value, next frame 8'h3C received correctly.
REQ-032 Back-to-back frames 8'h00, 8'hFF with zero idle gap -> two data_valid pulses, values 8'h00 then 8'hFF.
REQ-033 rst asserted at data bit 3 of 8'hC3 -> no pulses, all outputs at reset values; next frame 8'h81 received correctly.
REQ-034 With UART_RX_PARITY_EN, frame 8'h07 with a wrong parity bit -> one parity_error, no data_valid; correct parity -> data_received=8'h07.
